// File: rtl/mesh_link_port.sv
// rtl/mesh_link_port.sv - tile-side TX/RX buffering stage for one side of the mesh link
module mesh_link_port #(
  parameter int WIDTH    = 32,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [WIDTH-1:0]              send_data,
  output logic                          send_ready,
  input  logic                          send_done,
  input  logic [WIDTH-1:0]              recv_data,
  input  logic                          recv_valid,
  output logic                          recv_ready,
  output logic [WIDTH-1:0]              rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
  output logic                          err
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = $clog2(RX_DEPTH + 1);

  logic [WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]   tx_wr_ptr, tx_rd_ptr;
  logic [WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0]   rx_wr_ptr, rx_rd_ptr;

  logic tx_push, tx_pop, rx_push, rx_pop;

  // Readiness is decoded from the counts only; a full FIFO never bypasses a same-cycle pop.
  assign tx_ready   = (tx_count != TCW'(TX_DEPTH)) & ~rst;
  assign send_ready = (tx_count != '0);
  assign send_data  = tx_mem[tx_rd_ptr];
  assign recv_ready = (rx_count != RCW'(RX_DEPTH)) & ~rst;
  assign rx_valid   = (rx_count != '0);
  assign rx_data    = rx_mem[rx_rd_ptr];

  assign tx_push = tx_valid & tx_ready;
  assign tx_pop  = send_done & send_ready;
  assign rx_push = recv_valid & recv_ready;
  assign rx_pop  = rx_valid & rx_ready;

  // TX storage write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  // TX pointers and occupancy; pointers wrap naturally, the count separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + TCW'(1);
      else if (tx_pop && !tx_push) tx_count <= tx_count - TCW'(1);
    end
  end

  // RX storage write from the link.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= recv_data;
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + RCW'(1);
      else if (rx_pop && !rx_push) rx_count <= rx_count - RCW'(1);
    end
  end

  // Sticky link-side protocol error: consume from empty TX, or deliver into full RX.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((send_done && !send_ready) || (recv_valid && !recv_ready)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_link_port.sv
// tb/tb_mesh_link_port.sv - scoreboard bench for mesh_link_port with queue-based reference model
module tb_mesh_link_port;

  localparam int W   = 32;
  localparam int TXD = 4;
  localparam int RXD = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [W-1:0]     send_data;
  logic             send_ready;
  logic             send_done;
  logic [W-1:0]     recv_data;
  logic             recv_valid;
  logic             recv_ready;
  logic [W-1:0]     rx_data;
  logic             rx_valid;
  logic             rx_ready = 1'b0;
  logic [$clog2(TXD+1)-1:0] tx_count;
  logic [$clog2(RXD+1)-1:0] rx_count;
  logic             err;

  logic             lb = 1'b0;
  logic             go = 1'b0;
  logic             d_send_done = 1'b0;
  logic             d_recv_valid = 1'b0;
  logic [W-1:0]     d_recv_data = '0;

  // Link side: either driven directly, or looped back from this port's own TX.
  assign send_done  = lb ? (send_ready & recv_ready & go) : d_send_done;
  assign recv_valid = lb ? send_done : d_recv_valid;
  assign recv_data  = lb ? send_data : d_recv_data;

  mesh_link_port #(.WIDTH(W), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .send_data(send_data), .send_ready(send_ready), .send_done(send_done),
    .recv_data(recv_data), .recv_valid(recv_valid), .recv_ready(recv_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  int rx_got = 0;
  int tx_acc = 0;

  logic [W-1:0] mtx[$];
  logic [W-1:0] mrx[$];
  logic         merr;
  logic [W-1:0] exp_send[$];
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] mw;
  bit           m_tpush, m_tpop, m_rwr, m_rrd;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two word queues and a sticky flag, updated on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      mtx.delete(); mrx.delete(); exp_send.delete(); exp_rx.delete();
      merr = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      m_tpush = tx_valid && (mtx.size() < TXD);
      m_tpop  = send_done && (mtx.size() > 0);
      m_rwr   = recv_valid && (mrx.size() < RXD);
      m_rrd   = rx_ready && (mrx.size() > 0);
      if (send_done && mtx.size() == 0) merr = 1'b1;
      if (recv_valid && mrx.size() >= RXD) merr = 1'b1;
      mw = lb ? ((mtx.size() > 0) ? mtx[0] : '0) : d_recv_data;
      if (m_tpop) void'(mtx.pop_front());
      if (m_tpush) begin
        mtx.push_back(tx_data);
        exp_send.push_back(tx_data);
        tx_acc++;
      end
      if (m_rrd) void'(mrx.pop_front());
      if (m_rwr) begin
        mrx.push_back(mw);
        exp_rx.push_back(mw);
      end
    end
  end

  // Monitor: state checks, and scoreboard pops on every imminent handshake.
  always @(negedge clk) begin
    if (armed) begin
      chk("tx_count", W'(tx_count), W'(mtx.size()));
      chk("rx_count", W'(rx_count), W'(mrx.size()));
      chk("tx_ready", W'(tx_ready), W'(mtx.size() < TXD && !rst));
      chk("recv_ready", W'(recv_ready), W'(mrx.size() < RXD && !rst));
      chk("send_ready", W'(send_ready), W'(mtx.size() > 0));
      chk("rx_valid", W'(rx_valid), W'(mrx.size() > 0));
      chk("err", W'(err), W'(merr));
      if (mrx.size() > 0) chk("rx_head", rx_data, mrx[0]);
      if (!rst && send_ready && send_done) begin
        if (exp_send.size() == 0) chk("send_unexpected", W'(1), W'(0));
        else chk("send_data", send_data, exp_send.pop_front());
      end
      if (!rst && rx_valid && rx_ready) begin
        rx_got++;
        if (exp_rx.size() == 0) chk("rx_unexpected", W'(1), W'(0));
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0] words [5];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    words[3] = 32'h44; words[4] = 32'h55;

    // Reset then idle.
    tick(2);
    rst = 1'b0;
    tick(2);

    // Fill TX back-to-back; the fifth word must be refused.
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = words[i];
      tick();
    end
    tx_valid = 1'b0;
    d_send_done = 1'b1;
    tick(4);
    d_send_done = 1'b0;
    tick();
    chk("send_sb_drained", W'(exp_send.size()), W'(0));

    // Full TX with a simultaneous push offer and pop: word accepted only the next cycle.
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 32'hA0 + W'(i);
      tick();
    end
    tx_data = 32'h55;
    d_send_done = 1'b1;
    tick();
    d_send_done = 1'b0;
    tick();
    tx_valid = 1'b0;
    d_send_done = 1'b1;
    tick(4);
    d_send_done = 1'b0;
    tick();
    chk("send_sb_drained2", W'(exp_send.size()), W'(0));

    // Illegal link events set the sticky flag and change nothing else.
    d_send_done = 1'b1;
    tick();
    d_send_done = 1'b0;
    d_recv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_recv_data = 32'hB0 + W'(i);
      tick();
    end
    d_recv_valid = 1'b0;
    tick(3);
    rx_ready = 1'b1;
    tick(3);
    rx_ready = 1'b0;
    tick(2);

    // Reset with TX holding 3 and RX holding 1.
    tx_valid = 1'b1;
    d_recv_valid = 1'b1;
    d_recv_data = 32'hC0;
    tx_data = 32'hD0;
    tick();
    d_recv_valid = 1'b0;
    tx_data = 32'hD1;
    tick();
    tx_data = 32'hD2;
    tick();
    tx_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Loopback: random words, random core backpressure, a long stall window.
    lb = 1'b1;
    rx_got = 0;
    tx_acc = 0;
    for (int c = 0; c < 20000 && rx_got < 100; c++) begin
      tx_valid = (tx_acc < 100) && ($urandom_range(0, 3) != 0);
      tx_data  = $urandom;
      go       = ($urandom_range(0, 3) != 0);
      rx_ready = (c >= 40 && c < 70) ? 1'b0 : W'($urandom_range(0, 1)) != 0;
      tick();
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    go = 1'b0;
    tick();
    chk("loopback_words", W'(rx_got), W'(100));
    chk("loopback_sb_empty", W'(exp_rx.size()), W'(0));
    lb = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
